// File: rtl/lcd_ctrl.sv
// HD44780-compatible write controller: runs the power-on init sequence, then
// turns each accepted command/data byte into setup, EN pulse, hold and execution wait.
module lcd_ctrl #(
  parameter int CLK_PERIOD_NS = 20,
  parameter int SETUP_NS      = 60,
  parameter int EN_NS         = 460,
  parameter int HOLD_NS       = 20,
  parameter int CMD_WAIT_US   = 40,
  parameter int CLR_WAIT_US   = 1640,
  parameter int POWERON_US    = 15000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  function automatic int cyc_of(input int ns);
    int c;
    c = (ns + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int SETUP_CYC = cyc_of(SETUP_NS);
  localparam int EN_CYC    = cyc_of(EN_NS);
  localparam int HOLD_CYC  = cyc_of(HOLD_NS);
  localparam int WAIT_CYC  = cyc_of(CMD_WAIT_US * 1000);
  localparam int CLR_CYC   = cyc_of(CLR_WAIT_US * 1000);
  localparam int PON_CYC   = cyc_of(POWERON_US * 1000);
  localparam int MAX_CYC   = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, WAIT_CYC)),
                                  max2(CLR_CYC, PON_CYC));
  localparam int CNT_W     = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Terminal counts: the counter runs 0..N-1 inside each timed state.
  localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t EN_LAST    = cnt_t'(EN_CYC - 1);
  localparam cnt_t HOLD_LAST  = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t WAIT_LAST  = cnt_t'(WAIT_CYC - 1);
  localparam cnt_t CLR_LAST   = cnt_t'(CLR_CYC - 1);
  localparam cnt_t PON_LAST   = cnt_t'(PON_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRON, S_INIT, S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT
  } state_t;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] lcd_data_q, lcd_data_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic       lcd_en_q, lcd_en_d;
  logic       lcd_on_q, lcd_on_d;
  logic       ready_q, ready_d;
  logic       init_done_q, init_done_d;
  logic       is_clear;
  cnt_t       wait_last;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign is_clear  = !lcd_rs_q && (lcd_data_q[7:2] == 6'd0) && (lcd_data_q[1:0] != 2'd0);
  assign wait_last = is_clear ? CLR_LAST : WAIT_LAST;

  // NOTE: every _d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    lcd_data_d  = lcd_data_q;
    lcd_rs_d    = lcd_rs_q;
    init_done_d = init_done_q;
    lcd_on_d    = 1'b1;

    case (state_q)
      S_PWRON: begin
        if (cnt_q == PON_LAST) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_INIT: begin
        lcd_data_d = init_rom(idx_q);
        lcd_rs_d   = 1'b0;
        state_d    = S_SETUP;
        cnt_d      = '0;
      end
      S_IDLE: begin
        if (i_valid && ready_q) begin
          lcd_data_d = i_data;
          lcd_rs_d   = i_rs;
          state_d    = S_SETUP;
          cnt_d      = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_EN_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_EN_HI: begin
        if (cnt_q == EN_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_INIT;
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = S_PWRON;
        cnt_d   = '0;
      end
    endcase

    // EN and ready are decoded from the next state so both leave a flop glitch-free.
    lcd_en_d = (state_d == S_EN_HI);
    ready_d  = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_PWRON;
      cnt_q       <= '0;
      idx_q       <= '0;
      lcd_data_q  <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_on_q    <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lcd_data_q  <= lcd_data_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_en_q    <= lcd_en_d;
      lcd_on_q    <= lcd_on_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_init_done = init_done_q;
  assign o_lcd_data  = lcd_data_q;
  assign o_lcd_rs    = lcd_rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = lcd_en_q;
  assign o_lcd_on    = lcd_on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: a scoreboard of expected {rs,data} bytes is popped on every
// EN rising edge; the main sequence checks handshake latency and reset behaviour.
module tb_lcd_ctrl;

  localparam int S = 2, E = 5, H = 1, W = 50, C = 100, P = 100;
  localparam int INIT_CYC = P + 4 * (S + E + H + 1) + 3 * W + C;
  localparam int LAT_DATA = 1 + S + E + H + W;
  localparam int LAT_CLR  = 1 + S + E + H + C;
  // Back-to-back: one full byte sequence plus the IDLE cycle in which ready is seen.
  localparam int B2B_SEP  = S + E + H + W + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] lcd_data;

  lcd_ctrl #(
    .CLK_PERIOD_NS(20), .SETUP_NS(40), .EN_NS(100), .HOLD_NS(20),
    .CMD_WAIT_US(1), .CLR_WAIT_US(2), .POWERON_US(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_rs(rs), .i_data(data),
    .o_ready(ready), .o_init_done(init_done), .o_lcd_data(lcd_data),
    .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en), .o_lcd_on(lcd_on)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];
  int rise_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rom();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  function automatic int all_outputs();
    return int'({ready, init_done, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on});
  endfunction

  task automatic send(input logic r, input logic [7:0] d, output int t_acc);
    check("send_ready", int'(ready), 1);
    valid = 1'b1;
    rs    = r;
    data  = d;
    exp_q.push_back({r, d});
    tick();
    valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_ready(input int budget, output int t_rdy);
    int n;
    n = 0;
    while (!ready && n < budget) begin
      tick();
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
    t_rdy = cyc;
  endtask

  task automatic wait_init(input string tag, input int t0);
    int n;
    n = 0;
    while (!init_done && n < 1000) begin
      tick();
      n++;
    end
    check(tag, cyc - t0, INIT_CYC);
  endtask

  // Scoreboard monitor: each EN rise pops one expected byte, each fall checks the width.
  initial begin : monitor
    logic       en_prev;
    int         rise_at;
    logic [8:0] e;
    en_prev = 1'b0;
    rise_at = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        en_prev = 1'b0;
      end else begin
        if (lcd_en && !en_prev) begin
          rise_at = cyc;
          rise_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_en_pulse", int'({lcd_rs, lcd_data}), -1);
          end else begin
            e = exp_q.pop_front();
            check("en_byte", int'({lcd_rs, lcd_data}), int'(e));
          end
        end else if (!lcd_en && en_prev) begin
          check("en_width", cyc - rise_at, E);
        end
        en_prev = lcd_en;
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0, t_acc, t_rdy, n, r0;

    // 1: reset, power-on wait and init sequence
    repeat (3) tick();
    check("reset_outputs", all_outputs(), 0);
    push_rom();
    rst = 1'b0;
    t0  = cyc;
    tick();
    check("lcd_on_after_release", int'(lcd_on), 1);
    check("ready_during_pwron", int'(ready), 0);
    check("rw_low", int'(lcd_rw), 0);
    wait_init("init_time", t0);
    check("init_en_pulses", rise_q.size(), 4);
    if (rise_q.size() > 0) check("first_en_cycle", rise_q[0] - t0, P + 1 + S);
    check("init_ready", int'(ready), 1);
    check("init_scoreboard_empty", exp_q.size(), 0);

    // 2: data byte, exact EN window and normal wait
    send(1'b1, 8'h41, t_acc);
    check("data_at_T1", int'(lcd_data), 8'h41);
    check("rs_at_T1", int'(lcd_rs), 1);
    check("ready_low_at_T1", int'(ready), 0);
    check("en_at_T1", int'(lcd_en), 0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      check($sformatf("en_at_T%0d", k), int'(lcd_en), int'(k >= 3 && k <= 7));
    end
    wait_ready(200, t_rdy);
    check("ready_lat_data", t_rdy - t_acc + 1, LAT_DATA);

    // 3: clear display takes the long wait
    send(1'b0, 8'h01, t_acc);
    wait_ready(300, t_rdy);
    check("ready_lat_clear", t_rdy - t_acc + 1, LAT_CLR);

    // 3+4: set-address command with i_valid held high and a changing byte
    send(1'b0, 8'h80, t_acc);
    r0    = rise_q.size();
    valid = 1'b1;
    n     = 0;
    while (n < 200) begin
      data = 8'($urandom);
      rs   = 1'($urandom);
      tick();
      n++;
      if (ready) break;
      check("held_byte", int'({lcd_rs, lcd_data}), int'({1'b0, 8'h80}));
    end
    valid = 1'b0;
    check("ready_lat_cmd", cyc - t_acc + 1, LAT_DATA);
    check("one_en_while_held", rise_q.size() - r0, 1);

    // 5: reset while EN is high
    send(1'b1, 8'h55, t_acc);
    n = 0;
    while (!lcd_en && n < 20) begin
      tick();
      n++;
    end
    check("en_high_before_reset", int'(lcd_en), 1);
    rst = 1'b1;
    #1;
    check("en_drop_on_reset", int'(lcd_en), 0);
    check("outputs_on_reset", all_outputs(), 0);
    exp_q.delete();
    repeat (3) tick();
    push_rom();
    r0  = rise_q.size();
    rst = 1'b0;
    t0  = cyc;
    check("init_done_after_reset", int'(init_done), 0);
    wait_init("reinit_time", t0);
    check("reinit_en_pulses", rise_q.size() - r0, 4);

    // 6: back-to-back bytes with i_valid held
    r0 = rise_q.size();
    send(1'b1, 8'h48, t_acc);
    check("b2b_first_data", int'(lcd_data), 8'h48);
    valid = 1'b1;
    rs    = 1'b1;
    data  = 8'h49;
    exp_q.push_back({1'b1, 8'h49});
    wait_ready(200, t_rdy);
    tick();
    valid = 1'b0;
    check("b2b_second_data", int'(lcd_data), 8'h49);
    check("b2b_ready_low", int'(ready), 0);
    wait_ready(200, t_rdy);
    check("b2b_en_pulses", rise_q.size() - r0, 2);
    if (rise_q.size() >= 2)
      check("b2b_separation", rise_q[rise_q.size() - 1] - rise_q[rise_q.size() - 2], B2B_SEP);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
